// File: rtl/keypad_if.sv
// Keypad scanner signal bundle: row sense in, column drive and debounced key state out.
interface keypad_if;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic [3:0] key_value_o;
  logic       key_down_o;
  logic       key_press_o;

  modport master (
    input  row_i,
    output col_o,
    output key_value_o,
    output key_down_o,
    output key_press_o
  );

  modport slave (
    output row_i,
    input  col_o,
    input  key_value_o,
    input  key_down_o,
    input  key_press_o
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column sweep, first-key-per-sweep capture,
// sweep-level debounce and a registered stable-key output with a press pulse.
module keypad_scanner #(
  parameter int unsigned SETTLE_CYCLES   = 1000,
  parameter int unsigned DEBOUNCE_SWEEPS = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  keypad_if.master  kp
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES);
  localparam int unsigned MW = $clog2(DEBOUNCE_SWEEPS + 1);

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_e;

  col_e           col_q, col_d;
  logic [CW-1:0]  settle_q, settle_d;
  logic [3:0]     row_meta_q, row_sync_q;
  // Key results are {valid, code}; NONE is kept canonical as 5'b0.
  logic [4:0]     acc_q, acc_d;
  logic [4:0]     res_q, res_d;
  logic [4:0]     prev_q, prev_d;
  logic [4:0]     stable_q, stable_d;
  logic [MW-1:0]  match_q, match_d;
  logic           end_q, end_d;
  logic           press_q, press_d;

  logic           sample;
  logic           row_hit;
  logic [1:0]     hit_row;
  logic [3:0]     hit_code;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;  4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;  4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;  4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;  4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;  4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;  4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;  4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;  default:  code = 4'hD;
    endcase
    return code;
  endfunction

  assign sample = (settle_q == CW'(SETTLE_CYCLES - 1));

  // Column state: register / next-state / output decode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) col_q <= COL0;
    else       col_q <= col_d;
  end

  always_comb begin
    col_d = col_q;
    if (sample) begin
      case (col_q)
        COL0:    col_d = COL1;
        COL1:    col_d = COL2;
        COL2:    col_d = COL3;
        default: col_d = COL0;
      endcase
    end
  end

  always_comb begin
    case (col_q)
      COL0:    kp.col_o = 4'b1110;
      COL1:    kp.col_o = 4'b1101;
      COL2:    kp.col_o = 4'b1011;
      default: kp.col_o = 4'b0111;
    endcase
  end

  // Lowest pressed row wins within a column.
  always_comb begin
    row_hit = 1'b0;
    hit_row = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!row_sync_q[3-i]) begin
        row_hit = 1'b1;
        hit_row = 2'(3 - i);
      end
    end
    hit_code = key_code(hit_row, col_q);
  end

  always_comb begin
    settle_d = sample ? '0 : settle_q + 1'b1;
    acc_d    = acc_q;
    res_d    = res_q;
    prev_d   = prev_q;
    match_d  = match_q;
    stable_d = stable_q;
    end_d    = 1'b0;
    press_d  = 1'b0;

    if (sample) begin
      if (col_q == COL3) begin
        // Fold the last column in directly so the sweep result is ready one cycle later.
        end_d = 1'b1;
        acc_d = '0;
        if (acc_q[4])     res_d = acc_q;
        else if (row_hit) res_d = {1'b1, hit_code};
        else              res_d = '0;
      end else if (!acc_q[4] && row_hit) begin
        acc_d = {1'b1, hit_code};
      end
    end

    if (end_q) begin
      prev_d = res_q;
      if (res_q == prev_q)
        match_d = (match_q == MW'(DEBOUNCE_SWEEPS)) ? match_q : match_q + 1'b1;
      else
        match_d = MW'(1);
      if (match_d == MW'(DEBOUNCE_SWEEPS) && res_q != stable_q) begin
        stable_d = res_q;
        press_d  = res_q[4];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      settle_q   <= '0;
      acc_q      <= '0;
      res_q      <= '0;
      prev_q     <= '0;
      match_q    <= '0;
      stable_q   <= '0;
      end_q      <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      row_meta_q <= kp.row_i;
      row_sync_q <= row_meta_q;
      settle_q   <= settle_d;
      acc_q      <= acc_d;
      res_q      <= res_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      stable_q   <= stable_d;
      end_q      <= end_d;
      press_q    <= press_d;
    end
  end

  assign kp.key_value_o = stable_q[3:0];
  assign kp.key_down_o  = stable_q[4];
  assign kp.key_press_o = press_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural 4x4 keypad matrix.
module tb_keypad_scanner;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned DEB    = 2;
  localparam int unsigned SWEEP  = 4 * SETTLE;
  localparam int unsigned LAT    = (DEB + 1) * SWEEP + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  keypad_if kif();

  keypad_scanner #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_SWEEPS(DEB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .kp    (kif)
  );

  // pressed[r*4+c] closes the switch between row r and column c
  logic [15:0] pressed;
  always_comb begin
    kif.row_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kif.col_o[c] && pressed[r*4+c]) kif.row_i[r] = 1'b0;
  end

  int unsigned k;
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  typedef struct {
    string       name;
    logic [15:0] mask;
    int          sweeps;
    logic [3:0]  val;
    logic        down;
    int          pulses;
  } vec_t;

  vec_t vecs[9];
  vec_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt = 0;
  int cyc = 0;
  int last_pulse_cyc = 0;

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] one;
    one = 16'd1;
    return one << (r * 4 + c);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic [3:0] ec;
    logic [3:0] one;
    @(negedge clk);
    cyc++;
    if (kif.key_press_o) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
    end
    one = 4'b0001;
    ec  = rst ? 4'b1110 : ~(one << ((k / 4) % 4));
    check("col_o", {28'd0, kif.col_o}, {28'd0, ec});
  endtask

  initial begin
    vec_t e;
    int   p0, c0;

    pressed = '0;
    rst = 1'b1;
    repeat (3) tick();
    check("reset key_value", {28'd0, kif.key_value_o}, 32'h0);
    check("reset key_down",  {31'd0, kif.key_down_o},  32'h0);
    check("reset key_press", {31'd0, kif.key_press_o}, 32'h0);
    rst = 1'b0;

    vecs[0] = '{"idle",       16'h0,                       10, 4'h0, 1'b0, 0};
    vecs[1] = '{"key6",       key(1, 2),                    4, 4'h6, 1'b1, 1};
    vecs[2] = '{"rel6",       16'h0,                        4, 4'h0, 1'b0, 0};
    vecs[3] = '{"key0",       key(3, 0),                    4, 4'h0, 1'b1, 1};
    vecs[4] = '{"rel0",       16'h0,                        4, 4'h0, 1'b0, 0};
    vecs[5] = '{"key5+C",     key(1, 1) | key(2, 3),        4, 4'h5, 1'b1, 1};
    vecs[6] = '{"keyC",       key(2, 3),                    4, 4'hC, 1'b1, 1};
    vecs[7] = '{"holdC",      key(2, 3),                    4, 4'hC, 1'b1, 0};
    vecs[8] = '{"relC",       16'h0,                        4, 4'h0, 1'b0, 0};

    for (int i = 0; i < 9; i++) begin
      pressed = vecs[i].mask;
      sb.push_back(vecs[i]);
      p0 = pulse_cnt;
      c0 = cyc;
      repeat (vecs[i].sweeps * SWEEP) tick();
      e = sb.pop_front();
      check({e.name, " key_value"}, {28'd0, kif.key_value_o}, {28'd0, e.val});
      check({e.name, " key_down"},  {31'd0, kif.key_down_o},  {31'd0, e.down});
      check({e.name, " pulses"},    32'(pulse_cnt - p0),      32'(e.pulses));
      if (e.pulses > 0)
        check({e.name, " latency_ok"}, {31'd0, (last_pulse_cyc - c0) <= int'(LAT)}, 32'd1);
    end

    // Bounce: key 8 visible for exactly one sweep at a time, alternating with NONE
    p0 = pulse_cnt;
    for (int i = 0; i < 6; i++) begin
      pressed = key(2, 1);
      repeat (SWEEP) tick();
      check("bounce key_down", {31'd0, kif.key_down_o}, 32'd0);
      pressed = '0;
      repeat (SWEEP) tick();
    end
    repeat (3 * SWEEP) tick();
    check("bounce key_value", {28'd0, kif.key_value_o}, 32'h0);
    check("bounce key_down",  {31'd0, kif.key_down_o},  32'd0);
    check("bounce pulses",    32'(pulse_cnt - p0),      32'd0);

    // Asynchronous reset in the middle of column 2 with "A" held and accepted
    pressed = key(0, 3);
    p0 = pulse_cnt;
    repeat (4 * SWEEP) tick();
    check("A key_value", {28'd0, kif.key_value_o}, 32'hA);
    check("A key_down",  {31'd0, kif.key_down_o},  32'd1);
    check("A pulses",    32'(pulse_cnt - p0),      32'd1);
    for (int t = 0; t < 20 && kif.col_o != 4'b1011; t++) tick();
    check("reach col2", {28'd0, kif.col_o}, 32'hB);
    tick();
    #2 rst = 1'b1;
    #1;
    check("async rst col_o",     {28'd0, kif.col_o},       32'hE);
    check("async rst key_value", {28'd0, kif.key_value_o}, 32'h0);
    check("async rst key_down",  {31'd0, kif.key_down_o},  32'd0);
    check("async rst key_press", {31'd0, kif.key_press_o}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    p0 = pulse_cnt;
    for (int t = 0; t < int'(LAT) && !kif.key_down_o; t++) tick();
    check("reaccept key_down", {31'd0, kif.key_down_o}, 32'd1);
    repeat (2 * SWEEP) tick();
    check("reaccept key_value", {28'd0, kif.key_value_o}, 32'hA);
    check("reaccept pulses",    32'(pulse_cnt - p0),      32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1000, clocks each column is driven before its rows are sampled (min 4).
REQ-002 SHALL have parameter DEBOUNCE_SWEEPS, default 4, consecutive identical full-sweep results required to change the stable key (min 1).
REQ-003 SHALL have port clk_i  input  1  system clock.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port row_i  input  4  keypad row lines, active-low, asynchronous to clk_i.
REQ-006 SHALL have port col_o  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port key_value_o  output  4  debounced key code; feeds the note decoder's key input.
REQ-008 SHALL have port key_down_o  output  1  high while a debounced key is held.
REQ-009 SHALL have port key_press_o  output  1  one-cycle pulse when a new debounced key is accepted.

Function
REQ-010 SHALL pass row_i through a 2-flop synchronizer before any use.
REQ-011 SHALL scan columns 0,1,2,3 in order, repeating; col_o = ~(1 << c) for active column c.
REQ-012 SHALL hold each column for exactly SETTLE_CYCLES clocks (counter 0..SETTLE_CYCLES-1); synchronized rows are sampled on the cycle the counter equals SETTLE_CYCLES-1, and the column advances on the next cycle; one sweep = 4*SETTLE_CYCLES clocks.
REQ-013 SHALL map (row r, column c) to codes: r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: 0,F,E,D (columns 0..3 left to right).
REQ-014 SHALL, per sweep, record the first pressed key in scan order (lowest column, then lowest row); later pressed keys in the same sweep are ignored; no key pressed = sweep result NONE.
REQ-015 SHALL at sweep end (cycle after the column-3 sample) compare the sweep result with the previous sweep result: equal -> increment match counter (saturating at DEBOUNCE_SWEEPS); different -> reset counter to 1.
REQ-016 SHALL, when the match counter reaches DEBOUNCE_SWEEPS and the result differs from the stable state, update the stable state on that same sweep-end cycle (outputs visible next cycle).
REQ-017 SHALL on stable update to a key K: key_value_o = K, key_down_o = 1, key_press_o pulses 1 for one cycle; this includes a direct change from key K1 to K2 without intervening NONE.
REQ-018 SHALL on stable update to NONE: key_value_o = 4'h0, key_down_o = 0, no pulse.
REQ-019 SHALL NOT pulse key_press_o while the stable key stays unchanged (held key repeats nothing).
REQ-020 SHALL treat key "0" and NONE as distinct: key 0 gives key_value_o = 4'h0 with key_down_o = 1.
REQ-021 SHALL keep key_value_o, key_down_o constant between stable updates regardless of row_i activity.
REQ-022 SHALL produce first-press latency of at most (DEBOUNCE_SWEEPS+1) sweeps + 3 clocks from a stable row_i change.

Reset
REQ-023 SHALL on rst_i asserted, asynchronously: col_o = 4'b1110, key_value_o = 4'h0, key_down_o = 0, key_press_o = 0, settle counter 0, column 0, previous result NONE, match counter 0, stable state NONE, synchronizer flops 4'hF.
REQ-024 SHALL on reset mid-sweep discard the partial sweep; scanning restarts at column 0 on the first clock after rst_i deasserts.

Verification (SETTLE_CYCLES=4, DEBOUNCE_SWEEPS=2)
REQ-025 Reset then no key (row_i=4'hF) for 10 sweeps -> col_o cycles 1110,1101,1011,0111 every 4 clocks; key_down_o=0, key_value_o=0, no pulse.
REQ-026 Model row 1 low while column 2 driven, held -> after ~3 sweeps key_value_o=4'h6, key_down_o=1, exactly one key_press_o pulse; release -> key_down_o=0, key_value_o=0.
REQ-027 Key "8" present only one sweep (bounce), alternating with NONE -> no output change, no pulse.
REQ-028 Keys "5" (col1,row1) and "C" (col3,row2) held together -> key_value_o=4'h5; release "5" keeping "C" -> key_value_o=4'hC with a second pulse.
REQ-029 Key row3/col0 held -> key_value_o=4'h0, key_down_o=1, one pulse.
REQ-030 Assert rst_i mid-column-2 with key "A" held, stable -> outputs zero immediately; after release of reset "A" re-accepted after debounce with a new pulse.
